seg_scan_mux: RTL and testbench

Time-multiplexed scan driver for the stopwatch's four-digit seven-segment display. It sits directly downstream of the stopwatch top and consumes its four segment buses, A (most significant) through D (least significant). It drives one shared segment bus plus four active-low digit enables, cycling D, C, B, A. Each digit's pattern is snapshotted at the start of its slot so that a counter update mid-slot never tears the display.

---
 rtl/seg_scan_mux.sv | 121 ++++++++++++
 tb/tb_seg_scan_mux.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan driver: cycles D, C, B, A with per-slot snapshot and blanking.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_mux #(
  parameter int         REFRESH_DIV  = 50000,
  parameter int         BLANK_CYCLES = 2,
  parameter logic [6:0] SEG_OFF      = 7'b0000000,
  parameter logic [6:0] ZERO_PAT     = 7'b1111110,
  parameter int         DP_DIGIT     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] A,
  input  logic [6:0] B,
  input  logic [6:0] C,
  input  logic [6:0] D,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       slot_start
);

  localparam int            CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  // cnt holds the slot cycle that the next edge begins; outputs are registered from it.
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [6:0]    snap;
  logic [6:0]    sel_in;
  logic [6:0]    cur_pat;
  logic          start;
  logic          blank_ph;
  logic          lz;
  logic          cur_lz;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign start    = (cnt == '0);
  assign blank_ph = (int'(cnt) < BLANK_CYCLES);

  always_comb begin
    sel_in = D;
    case (idx)
      2'd0:    sel_in = D;
      2'd1:    sel_in = C;
      2'd2:    sel_in = B;
      default: sel_in = A;
    endcase
  end

`ifdef SEG_SCAN_LZB_EN
  logic lz_q;

  always_comb begin
    lz = 1'b0;
    case (idx)
      2'd3:    lz = (A == ZERO_PAT);
      2'd2:    lz = (A == ZERO_PAT) && (B == ZERO_PAT);
      2'd1:    lz = (A == ZERO_PAT) && (B == ZERO_PAT) && (C == ZERO_PAT);
      default: lz = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     lz_q <= 1'b0;
    else if (start) lz_q <= lz;
  end

  assign cur_lz = start ? lz : lz_q;
`else
  assign lz     = 1'b0;
  assign cur_lz = lz;
`endif

  // On the slot's first cycle the freshly sampled input bypasses snap (matters when BLANK_CYCLES=0).
  assign cur_pat = start ? sel_in : snap;

  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    if (!blank_ph) begin
      an_d = ~(4'b0001 << idx);
      if (!cur_lz) begin
        seg_d = cur_pat;
        dp_d  = (idx == 2'(DP_DIGIT));
      end
    end
  end

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    idx_nxt = idx;
    if (cnt == LAST) begin
      cnt_nxt = '0;
      idx_nxt = idx + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      snap       <= SEG_OFF;
      an         <= 4'b1111;
      seg        <= SEG_OFF;
      dp         <= 1'b0;
      slot_start <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      if (start) snap <= sel_in;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      slot_start <= start;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with REFRESH_DIV=4, BLANK_CYCLES=1, DP_DIGIT=2.
// Expected leading-zero behaviour follows SEG_SCAN_LZB_EN when the bench is built with it.
module tb_seg_scan_mux;

  localparam int         RD   = 4;
  localparam int         BC   = 1;
  localparam logic [6:0] ZP   = 7'b1111110;

  logic       clock;
  logic       reset;
  logic [6:0] A, B, C, D;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       slot_start;

  int checks = 0;
  int fails  = 0;
  int e      = 0;

  // Bench model state: pattern and blank decision latched at each slot start.
  logic [6:0] m_snap;
  logic       m_blank;

  seg_scan_mux #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .SEG_OFF     (7'b0000000),
    .ZERO_PAT    (ZP),
    .DP_DIGIT    (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .slot_start(slot_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {an, seg, dp, slot_start} after edge n (1-based) following reset release.
  function automatic logic [12:0] model(input int n);
    int k, ix;
    logic [6:0] p;
    logic bl;
    logic [3:0] a;
    k  = (n - 1) % RD;
    ix = ((n - 1) / RD) % 4;
    if (k == 0) begin
      case (ix)
        0:       p = D;
        1:       p = C;
        2:       p = B;
        default: p = A;
      endcase
      bl = 1'b0;
`ifdef SEG_SCAN_LZB_EN
      if (ix == 3) bl = (A == ZP);
      if (ix == 2) bl = (A == ZP) && (B == ZP);
      if (ix == 1) bl = (A == ZP) && (B == ZP) && (C == ZP);
`endif
      m_snap  = p;
      m_blank = bl;
    end
    if (k < BC) return {4'b1111, 7'b0000000, 1'b0, (k == 0)};
    a = 4'b1111;
    a[ix] = 1'b0;
    if (m_blank) return {a, 7'b0000000, 1'b0, 1'b0};
    return {a, m_snap, (ix == 2), 1'b0};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    e = 0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({an, seg, dp, slot_start} !== 13'b1111_0000000_0_0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got an=%b seg=%b dp=%b ss=%b, want an=1111 seg=0000000 dp=0 ss=0",
                 i, an, seg, dp, slot_start);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    e = 0;
    for (int i = 0; i < 8; i++) begin
      logic [12:0] x;
      @(posedge clock); #1;
      e++;
      x = model(e);
      checks++;
      if ({an, seg, dp, slot_start} !== x) begin
        fails++;
        $display("FAIL reset_release edge %0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                 e, an, seg, dp, slot_start, x[12:9], x[8:2], x[1], x[0]);
      end
    end
  endtask

  task automatic test_scan();
    A = 7'b1111001; B = 7'b0110011; C = 7'b1011011; D = 7'b0110000;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      logic [12:0] x;
      @(posedge clock); #1;
      e++;
      x = model(e);
      checks++;
      if ({an, seg, dp, slot_start} !== x) begin
        fails++;
        $display("FAIL scan edge %0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                 e, an, seg, dp, slot_start, x[12:9], x[8:2], x[1], x[0]);
      end
    end
  endtask

  task automatic test_dp();
    A = 7'b1110000; B = 7'b1111111; C = 7'b1011111; D = 7'b1111011;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic want;
      @(posedge clock); #1;
      e++;
      want = ((i / RD) == 2) && ((i % RD) >= BC);
      checks++;
      if (dp !== want) begin
        fails++;
        $display("FAIL dp edge %0d: got %b want %b", e, dp, want);
      end
    end
  endtask

  task automatic test_snapshot();
    A = 7'b1111001; B = 7'b0110011; C = 7'b0110000; D = 7'b1111110;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      logic [12:0] x;
      @(posedge clock); #1;
      e++;
      x = model(e);
      checks++;
      if ({an, seg, dp, slot_start} !== x) begin
        fails++;
        $display("FAIL snapshot edge %0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                 e, an, seg, dp, slot_start, x[12:9], x[8:2], x[1], x[0]);
      end
      if (e == 7) C = 7'b1101101;
    end
    checks++;
    if (seg !== 7'b1101101) begin
      fails++;
      $display("FAIL snapshot_new: got seg=%b want 1101101", seg);
    end
  endtask

  task automatic test_async_reset();
    A = 7'b1111001; B = 7'b0110011; C = 7'b1011011; D = 7'b0110000;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      e++;
    end
    checks++;
    if (an !== 4'b1011 || seg !== B) begin
      fails++;
      $display("FAIL async_pre: got an=%b seg=%b want an=1011 seg=%b", an, seg, B);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, slot_start} !== 13'b1111_0000000_0_0) begin
      fails++;
      $display("FAIL async_reset: got an=%b seg=%b dp=%b ss=%b want 1111 0000000 0 0",
               an, seg, dp, slot_start);
    end
    @(negedge clock);
    reset = 1'b1;
    e = 0;
    for (int i = 0; i < 8; i++) begin
      logic [12:0] x;
      @(posedge clock); #1;
      e++;
      x = model(e);
      checks++;
      if ({an, seg, dp, slot_start} !== x) begin
        fails++;
        $display("FAIL async_restart edge %0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                 e, an, seg, dp, slot_start, x[12:9], x[8:2], x[1], x[0]);
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] ab_want;
`ifdef SEG_SCAN_LZB_EN
    ab_want = 7'b0000000;
`else
    ab_want = ZP;
`endif
    A = ZP; B = ZP; C = 7'b0110000; D = ZP;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      int ix;
      logic [6:0] sw;
      logic [3:0] aw;
      @(posedge clock); #1;
      e++;
      ix = i / RD;
      if ((i % RD) < BC) continue;
      case (ix)
        0:       sw = ZP;
        1:       sw = 7'b0110000;
        default: sw = ab_want;
      endcase
      aw = 4'b1111;
      aw[ix] = 1'b0;
      checks++;
      if (seg !== sw || an !== aw) begin
        fails++;
        $display("FAIL lzb edge %0d: got an=%b seg=%b want an=%b seg=%b", e, an, seg, aw, sw);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    A = '0; B = '0; C = '0; D = '0;
    m_snap = '0;
    m_blank = 1'b0;
    test_reset();
    test_scan();
    test_dp();
    test_snapshot();
    test_async_reset();
    test_lzb();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
